// File: rtl/lvds_panel_sequencer_if.sv
// Control/status bundle between the panel sequencer and its requester.
// The master is the side that requests panel power and watches the status;
// the slave is the sequencer itself.
`timescale 1ns/1ps

interface lvds_panel_sequencer_if;
    // Request side
    logic       panel_on_req;   // level: 1 = panel wanted on
    logic       frame_start;    // one-cycle pulse at start of vertical blanking
    logic       fault;          // level: panel/supply fault

    // Status side
    logic       vdd_en;         // panel logic supply enable
    logic       lvds_en;        // serializer output enable
    logic       bl_en;          // backlight enable
    logic       ready;          // panel fully on
    logic       fault_flag;     // sticky fault indicator
    logic [2:0] state;          // current sequencer state code

    modport master (
        output panel_on_req, frame_start, fault,
        input  vdd_en, lvds_en, bl_en, ready, fault_flag, state
    );

    modport slave (
        input  panel_on_req, frame_start, fault,
        output vdd_en, lvds_en, bl_en, ready, fault_flag, state
    );
endinterface

// File: rtl/lvds_panel_sequencer.sv
// Power/enable sequencer for the LVDS LCD panel.
// Walks panel VDD, LVDS output enable and backlight through the timed power-up
// and power-down ramps, aligning LVDS enable to a frame boundary so serialized
// data never drives an unpowered panel. Runs in the DotClock domain.
`timescale 1ns/1ps

module lvds_panel_sequencer #(
    parameter int unsigned T_VDD        = 72000,
    parameter int unsigned T_LVDS       = 72000,
    parameter int unsigned T_BLOFF      = 72000,
    parameter int unsigned T_LVDSOFF    = 72000,
    parameter int unsigned T_HOLD       = 720000,
    parameter int unsigned SYNC_TIMEOUT = 2000000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    lvds_panel_sequencer_if.slave   bus_if
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_VDD     = 3'd1,
        ST_SYNC    = 3'd2,
        ST_LVDS    = 3'd3,
        ST_ON      = 3'd4,
        ST_BLOFF   = 3'd5,
        ST_LVDSOFF = 3'd6,
        ST_HOLD    = 3'd7
    } state_t;

    // A dwell of T cycles loads T-1; a dwell of 0 behaves as a dwell of 1.
    function automatic logic [CNT_W-1:0] load_of(input int unsigned t);
        int unsigned v;
        v = (t == 0) ? 0 : t - 1;
        return CNT_W'(v);
    endfunction

    localparam logic [CNT_W-1:0] LD_VDD     = load_of(T_VDD);
    localparam logic [CNT_W-1:0] LD_SYNC    = load_of(SYNC_TIMEOUT);
    localparam logic [CNT_W-1:0] LD_LVDS    = load_of(T_LVDS);
    localparam logic [CNT_W-1:0] LD_BLOFF   = load_of(T_BLOFF);
    localparam logic [CNT_W-1:0] LD_LVDSOFF = load_of(T_LVDSOFF);
    localparam logic [CNT_W-1:0] LD_HOLD    = load_of(T_HOLD);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_flag_q, fault_flag_d;
    logic             vdd_en_q, lvds_en_q, bl_en_q, ready_q;
    logic             cnt_zero;
    logic             req;

    assign req      = bus_if.panel_on_req;
    assign cnt_zero = (cnt_q == '0);

    // Next-state and sticky fault flag: fault overrides everything, then
    // request drops reverse only the steps already taken, then timers/sync.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d      = state_q;
        fault_flag_d = fault_flag_q;

        if (bus_if.fault && (state_q != ST_OFF) && (state_q != ST_HOLD)) begin
            state_d      = ST_HOLD;
            fault_flag_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (fault_flag_q) begin
                        // Stay off until the requester lets go with the fault gone.
                        if (!req && !bus_if.fault) fault_flag_d = 1'b0;
                    end else if (req) begin
                        state_d = ST_VDD;
                    end
                end
                ST_VDD: begin
                    if (!req)          state_d = ST_HOLD;
                    else if (cnt_zero) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    // Only pulses sampled while already in SYNC count, so a
                    // pulse coincident with the entry edge is ignored.
                    if (!req)                                state_d = ST_HOLD;
                    else if (bus_if.frame_start || cnt_zero) state_d = ST_LVDS;
                end
                ST_LVDS: begin
                    if (!req)          state_d = ST_LVDSOFF;
                    else if (cnt_zero) state_d = ST_ON;
                end
                ST_ON: begin
                    if (!req) state_d = ST_BLOFF;
                end
                // Power-down always runs to completion regardless of the request.
                ST_BLOFF: begin
                    if (cnt_zero) state_d = ST_LVDSOFF;
                end
                ST_LVDSOFF: begin
                    if (cnt_zero) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt_zero) state_d = ST_OFF;
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Dwell counter: load on state entry, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                ST_VDD:     cnt_d = LD_VDD;
                ST_SYNC:    cnt_d = LD_SYNC;
                ST_LVDS:    cnt_d = LD_LVDS;
                ST_BLOFF:   cnt_d = LD_BLOFF;
                ST_LVDSOFF: cnt_d = LD_LVDSOFF;
                ST_HOLD:    cnt_d = LD_HOLD;
                default:    cnt_d = '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State register with enables decoded from the state being entered, so
    // every output changes on the same edge as the state.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; a reset mid-sequence drops every enable
        // on the next edge with no ramp-down.
        if (rst) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            fault_flag_q <= 1'b0;
            vdd_en_q     <= 1'b0;
            lvds_en_q    <= 1'b0;
            bl_en_q      <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_flag_q <= fault_flag_d;
            vdd_en_q     <= (state_d inside {ST_VDD, ST_SYNC, ST_LVDS, ST_ON,
                                             ST_BLOFF, ST_LVDSOFF});
            lvds_en_q    <= (state_d inside {ST_LVDS, ST_ON, ST_BLOFF});
            bl_en_q      <= (state_d == ST_ON);
            ready_q      <= (state_d == ST_ON);
        end
    end

    assign bus_if.vdd_en     = vdd_en_q;
    assign bus_if.lvds_en    = lvds_en_q;
    assign bus_if.bl_en      = bl_en_q;
    assign bus_if.ready      = ready_q;
    assign bus_if.fault_flag = fault_flag_q;
    assign bus_if.state      = state_q;

endmodule

// File: tb/tb_lvds_panel_sequencer.sv
// Self-checking bench for lvds_panel_sequencer with short dwell times.
// Each cycle pushes the expected status snapshot, then pops it and compares
// against the DUT once the edge has settled.
`timescale 1ns/1ps

module tb_lvds_panel_sequencer;

    localparam logic [2:0] S_OFF = 3'd0, S_VDD = 3'd1, S_SYNC = 3'd2, S_LVDS = 3'd3,
                           S_ON = 3'd4, S_BLOFF = 3'd5, S_LVDSOFF = 3'd6, S_HOLD = 3'd7;

    typedef struct packed {
        logic [2:0] state;
        logic       vdd;
        logic       lvds;
        logic       bl;
        logic       rdy;
        logic       ff;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst;
    snap_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    lvds_panel_sequencer_if bus ();

    lvds_panel_sequencer #(
        .T_VDD(4), .T_LVDS(3), .T_BLOFF(2), .T_LVDSOFF(3), .T_HOLD(5),
        .SYNC_TIMEOUT(10), .CNT_W(32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    // Expected enables follow from the state: VDD on VDD..LVDSOFF,
    // LVDS on LVDS/ON/BLOFF, backlight and ready only in ON.
    function automatic snap_t expect_of(input logic [2:0] st, input logic ff);
        snap_t s;
        s.state = st;
        s.vdd   = (st >= S_VDD) && (st <= S_LVDSOFF);
        s.lvds  = (st == S_LVDS) || (st == S_ON) || (st == S_BLOFF);
        s.bl    = (st == S_ON);
        s.rdy   = (st == S_ON);
        s.ff    = ff;
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.state = bus.state;
        s.vdd   = bus.vdd_en;
        s.lvds  = bus.lvds_en;
        s.bl    = bus.bl_en;
        s.rdy   = bus.ready;
        s.ff    = bus.fault_flag;
        return s;
    endfunction

    // Drive inputs for the next edge, queue the expectation, advance past it.
    task automatic drive(input logic r, input logic req, input logic fs, input logic flt,
                         input logic [2:0] st, input logic ff);
        rst              = r;
        bus.panel_on_req = req;
        bus.frame_start  = fs;
        bus.fault        = flt;
        sb_q.push_back(expect_of(st, ff));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst              = 1'b1;
        bus.panel_on_req = 1'b0;
        bus.frame_start  = 1'b0;
        bus.fault        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        snap_t exp, got;
        for (int e = 0; e < 3; e++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, S_OFF, 1'b0);
            exp = sb_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset e=%0d: got %b expected %b", e, got, exp);
            end
        end
    endtask

    // Request at edge 0, frame_start sampled at edge 7.
    task automatic test_power_up();
        snap_t exp, got;
        logic [2:0] st;
        for (int e = 0; e < 12; e++) begin
            st = (e < 4) ? S_VDD : (e < 7) ? S_SYNC : (e < 10) ? S_LVDS : S_ON;
            drive(1'b0, 1'b1, (e == 7), 1'b0, st, 1'b0);
            exp = sb_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL power_up e=%0d: got %b expected %b", e, got, exp);
            end
        end
    endtask

    // Request drops at edge 0 from ON; re-raised during LVDSOFF, which must be
    // ignored until OFF is reached at edge 10 and re-evaluated at edge 11.
    task automatic test_power_down();
        snap_t exp, got;
        logic [2:0] st;
        for (int e = 0; e < 11; e++) begin
            st = (e < 2) ? S_BLOFF : (e < 5) ? S_LVDSOFF : (e < 10) ? S_HOLD : S_OFF;
            drive(1'b0, (e >= 3), 1'b0, 1'b0, st, 1'b0);
            exp = sb_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL power_down e=%0d: got %b expected %b", e, got, exp);
            end
        end
    endtask

    // Back-to-back with power-down: OFF re-powers, no frame_start ever arrives.
    task automatic test_sync_timeout();
        snap_t exp, got;
        logic [2:0] st;
        for (int e = 0; e < 19; e++) begin
            st = (e < 4) ? S_VDD : (e < 14) ? S_SYNC : (e < 17) ? S_LVDS : S_ON;
            drive(1'b0, 1'b1, 1'b0, 1'b0, st, 1'b0);
            exp = sb_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL sync_timeout e=%0d: got %b expected %b", e, got, exp);
            end
        end
    endtask

    // Pulse on the SYNC entry edge (4) is ignored; pulse at 6 takes effect.
    // Request drops two cycles into LVDS.
    task automatic test_abort_lvds();
        snap_t exp, got;
        logic [2:0] st;
        apply_reset();
        for (int e = 0; e < 18; e++) begin
            st = (e < 4) ? S_VDD : (e < 6) ? S_SYNC : (e < 8) ? S_LVDS :
                 (e < 11) ? S_LVDSOFF : (e < 16) ? S_HOLD : S_OFF;
            drive(1'b0, (e < 8), (e == 4) || (e == 6), 1'b0, st, 1'b0);
            exp = sb_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort_lvds e=%0d: got %b expected %b", e, got, exp);
            end
        end
    endtask

    task automatic test_abort_sync();
        snap_t exp, got;
        logic [2:0] st;
        apply_reset();
        for (int e = 0; e < 11; e++) begin
            st = (e < 4) ? S_VDD : (e < 5) ? S_SYNC : (e < 10) ? S_HOLD : S_OFF;
            drive(1'b0, (e < 5), 1'b0, 1'b0, st, 1'b0);
            exp = sb_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort_sync e=%0d: got %b expected %b", e, got, exp);
            end
        end
    endtask

    // One-cycle fault in ON; OFF holds while req=1, clears on req=0, re-powers.
    task automatic test_fault();
        snap_t exp, got;
        logic [2:0] st;
        apply_reset();
        for (int e = 0; e < 23; e++) begin
            st = (e < 4) ? S_VDD : (e < 7) ? S_SYNC : (e < 10) ? S_LVDS :
                 (e < 12) ? S_ON : (e < 17) ? S_HOLD : (e < 21) ? S_OFF : S_VDD;
            drive(1'b0, (e != 20), (e == 7), (e == 12), st, (e >= 12) && (e < 20));
            exp = sb_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fault e=%0d: got %b expected %b", e, got, exp);
            end
        end
    endtask

    // Reset lands in LVDSOFF with VDD still on; then the power-up timing repeats.
    task automatic test_reset_mid();
        snap_t exp, got;
        logic [2:0] st;
        apply_reset();
        for (int e = 0; e < 27; e++) begin
            st = (e < 4) ? S_VDD : (e < 7) ? S_SYNC : (e < 10) ? S_LVDS :
                 (e < 11) ? S_ON : (e < 13) ? S_BLOFF : (e < 14) ? S_LVDSOFF :
                 (e < 15) ? S_OFF : (e < 19) ? S_VDD : (e < 22) ? S_SYNC :
                 (e < 25) ? S_LVDS : S_ON;
            drive((e == 14), !((e >= 11) && (e < 14)), (e == 7) || (e == 22), 1'b0, st, 1'b0);
            exp = sb_q.pop_front();
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid e=%0d: got %b expected %b", e, got, exp);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.panel_on_req = 1'b0;
        bus.frame_start  = 1'b0;
        bus.fault        = 1'b0;
        #1;
        test_reset();
        test_power_up();
        test_power_down();
        test_sync_timeout();
        test_abort_lvds();
        test_abort_sync();
        test_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
